// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: queues branch-unit and pre-decode updates
// and sweeps every entry invalid after reset or flush.
module btb_update_ctrl #(
    parameter int ENTRIES    = 1024,
    parameter int IDX_LO     = 1,
    parameter int IDX_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [29:0] ex_pc,
    input  logic [1:0]  ex_type,
    input  logic [29:0] ex_target,
    input  logic        pd_valid,
    output logic        pd_ready,
    input  logic [29:0] pd_pc,
    input  logic [1:0]  pd_type,
    input  logic [29:0] pd_target,
    output logic        btb_we,
    output logic [29:0] btb_wr_pc,
    output logic [1:0]  btb_wr_type,
    output logic [29:0] btb_wr_target,
    output logic        btb_wr_valid,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic [PW:0]      count;
    logic             room;
    logic             empty;
    logic             push;
    logic             ex_fire;
    logic             pd_fire;

    logic [29:0] in_pc;
    logic [1:0]  in_type;
    logic [29:0] in_tgt;

    logic [29:0] q_pc   [FIFO_DEPTH];
    logic [1:0]  q_type [FIFO_DEPTH];
    logic [29:0] q_tgt  [FIFO_DEPTH];

    logic        we_d;
    logic [29:0] pc_d;
    logic [1:0]  type_d;
    logic [29:0] tgt_d;
    logic        val_d;
    logic [29:0] clr_pc;

    assign count = wptr_q - rptr_q;
    assign room  = count < (PW+1)'(FIFO_DEPTH);
    assign empty = (count == '0);
    assign busy  = (state_q == CLEAR);

    // Readies look only at registered occupancy, never at a same-cycle pop.
    assign ex_ready = (state_q == RUN) && !flush && room;
    assign pd_ready = (state_q == RUN) && !flush && room && !ex_valid;

    assign ex_fire = ex_valid && ex_ready;
    assign pd_fire = pd_valid && pd_ready;
    assign push    = ex_fire || pd_fire;

    assign in_pc   = ex_fire ? ex_pc     : pd_pc;
    assign in_type = ex_fire ? ex_type   : pd_type;
    assign in_tgt  = ex_fire ? ex_target : pd_target;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr_q[PW-1:0]]   <= in_pc;
            q_type[wptr_q[PW-1:0]] <= in_type;
            q_tgt[wptr_q[PW-1:0]]  <= in_tgt;
        end
    end

    always_comb begin
        clr_pc = '0;
        clr_pc[IDX_LO +: IDX_W] = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q + {{PW{1'b0}}, push};
        rptr_d  = rptr_q;
        we_d    = 1'b0;
        pc_d    = btb_wr_pc;
        type_d  = btb_wr_type;
        tgt_d   = btb_wr_target;
        val_d   = btb_wr_valid;
        if (flush) begin
            // The flush edge itself issues the index-0 clear write.
            state_d = CLEAR;
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = IDX_W'(1);
            we_d    = 1'b1;
            pc_d    = '0;
            type_d  = '0;
            tgt_d   = '0;
            val_d   = 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    we_d   = 1'b1;
                    pc_d   = clr_pc;
                    type_d = '0;
                    tgt_d  = '0;
                    val_d  = 1'b0;
                    cnt_d  = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(ENTRIES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (!empty) begin
                        rptr_d = rptr_q + {{PW{1'b0}}, 1'b1};
                        we_d   = 1'b1;
                        pc_d   = q_pc[rptr_q[PW-1:0]];
                        type_d = q_type[rptr_q[PW-1:0]];
                        tgt_d  = q_tgt[rptr_q[PW-1:0]];
                        val_d  = (q_type[rptr_q[PW-1:0]] != 2'b00);
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= CLEAR;
            cnt_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            btb_we        <= 1'b0;
            btb_wr_pc     <= '0;
            btb_wr_type   <= '0;
            btb_wr_target <= '0;
            btb_wr_valid  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            btb_we        <= we_d;
            btb_wr_pc     <= pc_d;
            btb_wr_type   <= type_d;
            btb_wr_target <= tgt_d;
            btb_wr_valid  <= val_d;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: clear sweep, queued updates,
// arbitration, flush restart and asynchronous reset.
module tb_btb_update_ctrl;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [29:0] ex_pc;
    logic [1:0]  ex_type;
    logic [29:0] ex_target;
    logic        pd_valid;
    logic        pd_ready;
    logic [29:0] pd_pc;
    logic [1:0]  pd_type;
    logic [29:0] pd_target;
    logic        btb_we;
    logic [29:0] btb_wr_pc;
    logic [1:0]  btb_wr_type;
    logic [29:0] btb_wr_target;
    logic        btb_wr_valid;
    logic        busy;

    int tests;
    int fails;

    btb_update_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_pc         (ex_pc),
        .ex_type       (ex_type),
        .ex_target     (ex_target),
        .pd_valid      (pd_valid),
        .pd_ready      (pd_ready),
        .pd_pc         (pd_pc),
        .pd_type       (pd_type),
        .pd_target     (pd_target),
        .btb_we        (btb_we),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_type   (btb_wr_type),
        .btb_wr_target (btb_wr_target),
        .btb_wr_valid  (btb_wr_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex_v;
        logic [29:0] ex_pc;
        logic [1:0]  ex_t;
        logic [29:0] ex_tg;
        logic        pd_v;
        logic [29:0] pd_pc;
        logic [1:0]  pd_t;
        logic [29:0] pd_tg;
        logic        e_exr;
        logic        e_pdr;
        logic        e_we;
        logic [29:0] e_pc;
        logic [1:0]  e_t;
        logic [29:0] e_tg;
        logic        e_val;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wr_word();
        return {btb_we, btb_wr_valid, btb_wr_type, btb_wr_pc, btb_wr_target};
    endfunction

    function automatic logic [63:0] clr_word(input int idx);
        logic [29:0] p;
        p = 30'(idx) << 1;
        return {1'b1, 1'b0, 2'b00, p, 30'h0};
    endfunction

    task automatic idle_inputs();
        flush    = 1'b0;
        ex_valid = 1'b0;
        ex_pc    = '0;
        ex_type  = '0;
        ex_target = '0;
        pd_valid = 1'b0;
        pd_pc    = '0;
        pd_type  = '0;
        pd_target = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        idle_inputs();

        vec[0] = '{1, 30'h123, 1, 30'h4000, 0, 0, 0, 0,
                   1, 0, 0, 30'h7FE, 0, 30'h0, 0};
        vec[1] = '{0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 0, 30'h7FE, 0, 30'h0, 0};
        vec[2] = '{1, 30'h100, 2, 30'h111, 1, 30'h200, 3, 30'h222,
                   1, 0, 1, 30'h123, 1, 30'h4000, 1};
        vec[3] = '{0, 0, 0, 0, 1, 30'h200, 3, 30'h222,
                   1, 1, 0, 30'h123, 1, 30'h4000, 1};
        vec[4] = '{0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 1, 30'h100, 2, 30'h111, 1};
        vec[5] = '{1, 30'h55, 0, 30'h3FFFFFFF, 0, 0, 0, 0,
                   1, 0, 1, 30'h200, 3, 30'h222, 1};
        vec[6] = '{0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 0, 30'h200, 3, 30'h222, 1};
        vec[7] = '{0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 1, 30'h55, 0, 30'h3FFFFFFF, 0};
        vec[8] = '{0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 0, 30'h55, 0, 30'h3FFFFFFF, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", wr_word(), 64'h0);
        check("reset_busy_ready", {62'h0, busy, ex_ready}, 64'h2);

        @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #2;
            check("sweep_write", wr_word(), clr_word(i));
        end
        check("post_sweep_busy_ready", {62'h0, busy, ex_ready}, 64'h1);
        @(posedge clk);
        #2;
        check("post_sweep_we", {63'h0, btb_we}, 64'h0);

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            ex_valid  = vec[i].ex_v;
            ex_pc     = vec[i].ex_pc;
            ex_type   = vec[i].ex_t;
            ex_target = vec[i].ex_tg;
            pd_valid  = vec[i].pd_v;
            pd_pc     = vec[i].pd_pc;
            pd_type   = vec[i].pd_t;
            pd_target = vec[i].pd_tg;
            #1;
            check($sformatf("vec%0d_ready", i), {62'h0, ex_ready, pd_ready},
                  {62'h0, vec[i].e_exr, vec[i].e_pdr});
            check($sformatf("vec%0d_write", i), wr_word(),
                  {vec[i].e_we, vec[i].e_val, vec[i].e_t,
                   vec[i].e_pc, vec[i].e_tg});
        end

        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (j < 5) begin
                pd_valid  = 1'b1;
                pd_pc     = 30'h300 + 30'(j);
                pd_type   = 2'b01;
                pd_target = 30'h10 + 30'(j);
            end
            #1;
            if (j < 5)
                check($sformatf("pd_burst_ready%0d", j),
                      {63'h0, pd_ready}, 64'h1);
            if (j >= 2 && j < 7)
                check($sformatf("pd_burst_write%0d", j - 2), wr_word(),
                      {1'b1, 1'b1, 2'b01, 30'h300 + 30'(j - 2),
                       30'h10 + 30'(j - 2)});
            if (j == 7)
                check("pd_burst_drain", {63'h0, btb_we}, 64'h0);
        end

        @(posedge clk);
        #1;
        ex_valid  = 1'b1;
        ex_pc     = 30'h3A5;
        ex_type   = 2'b01;
        ex_target = 30'h777;
        #1;
        check("pre_flush_accept", {63'h0, ex_ready}, 64'h1);
        @(posedge clk);
        #1;
        idle_inputs();
        flush    = 1'b1;
        ex_valid = 1'b1;
        ex_pc    = 30'h3A6;
        pd_valid = 1'b1;
        #1;
        check("flush_readies_low", {62'h0, ex_ready, pd_ready}, 64'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("flush_idx0", wr_word(), clr_word(0));
        check("flush_busy", {63'h0, busy}, 64'h1);
        for (int i = 1; i < 500; i++) begin
            @(posedge clk);
            #2;
            check("sweep1_write", wr_word(), clr_word(i));
        end

        @(posedge clk);
        #1;
        flush    = 1'b1;
        ex_valid = 1'b1;
        #1;
        check("flush2_readies_low", {62'h0, ex_ready, pd_ready}, 64'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("flush2_idx0", wr_word(), clr_word(0));
        for (int i = 1; i < 1024; i++) begin
            @(posedge clk);
            #2;
            check("sweep2_write", wr_word(), clr_word(i));
            if (i < 1023)
                check("sweep2_busy", {63'h0, busy}, 64'h1);
        end
        check("sweep2_done_busy", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #2;
        check("queued_dropped", {63'h0, btb_we}, 64'h0);

        @(posedge clk);
        #1;
        ex_valid  = 1'b1;
        ex_pc     = 30'h77;
        ex_type   = 2'b10;
        ex_target = 30'h99;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #2;
        check("pre_reset_write", wr_word(),
              {1'b1, 1'b1, 2'b10, 30'h77, 30'h99});
        #1 rstn = 1'b0;
        #1;
        check("async_reset_outputs", wr_word(), 64'h0);
        check("async_reset_busy", {62'h0, busy, ex_ready}, 64'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
